// File: rtl/count_seq_pkg.sv
// Shared definitions for the count_seq_ctrl sequencing controller:
// FSM state encoding and default counter/settle dimensions.
package count_seq_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_SETTLE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_seq_shadow.sv
// Shadow copy of the external counter value. It advances on every edge
// the controller enables the counter, wrapping mod 2^WIDTH.
// With COUNT_SEQ_CHECK_EN defined, a comparator checks the counter's Q
// against the shadow inside the checking window and raises a sticky err.
// Without it, err is tied low and Q is not observed.
module count_seq_shadow
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             restart,
  input  logic             inc,
  input  logic             check,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] shadow,
  output logic             err
);

  logic [WIDTH-1:0] shadow_r;

  // Shadow count: zeroed on reset or accepted start, advances with each enabled edge.
  always_ff @(posedge clock) begin
    if (!clear) begin
      shadow_r <= WIDTH'(0);
    end else if (restart) begin
      shadow_r <= WIDTH'(0);
    end else if (inc) begin
      shadow_r <= shadow_r + WIDTH'(1);
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign shadow = shadow_r;

`ifdef COUNT_SEQ_CHECK_EN
  logic err_r;

  // Sticky mismatch flag: Q at this edge reflects the increment of the
  // previous edge, so it is compared against the shadow before it updates.
  always_ff @(posedge clock) begin
    if (!clear) begin
      err_r <= 1'b0;
    end else if (restart) begin
      err_r <= 1'b0;
    end else if (check && (q != shadow_r)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  logic unused_check_s;

  assign unused_check_s = ^{q, check};
  assign err            = 1'b0;
`endif

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a 4-bit master-slave JK synchronous counter.
// Clears the counter for SETTLE cycles, then enables it for exactly
// `target` increments (pause stretches the run), and pulses done.
// abort returns to IDLE from any state, leaving the counter value intact.
// Optional Q-vs-shadow checking is enabled by defining COUNT_SEQ_CHECK_EN.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic             cnt_en,
  output logic             cnt_clr_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0]       SETTLE_LOAD = 3'(SETTLE - 1);
  localparam logic [WIDTH-1:0] REM_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] REM_ZERO    = WIDTH'(0);

  state_t           state_r;
  logic [WIDTH-1:0] target_r;
  logic [2:0]       settle_r;
  logic             cnt_en_r;
  logic             cnt_clr_n_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] shadow_s;
  logic [WIDTH-1:0] remaining_s;
  logic             start_acc_s;
  logic             check_win_s;
  logic             shadow_inc_s;

  // Remaining increments derive from the shadow; also decode start acceptance and the check window.
  always_comb begin
    remaining_s  = target_r - shadow_s;
    shadow_inc_s = cnt_en_r;
    start_acc_s  = 1'b0;
    check_win_s  = 1'b0;
    if (state_r == IDLE) begin
      start_acc_s = start & ~abort;
    end else begin
      start_acc_s = 1'b0;
    end
    if ((state_r == RUN) || (state_r == DONE)) begin
      check_win_s = 1'b1;
    end else begin
      check_win_s = 1'b0;
    end
  end

  // Sequencing FSM with registered counter controls and status outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r     <= IDLE;
      target_r    <= REM_ZERO;
      settle_r    <= 3'd0;
      cnt_en_r    <= 1'b0;
      cnt_clr_n_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_en_r <= 1'b0;
          if (start_acc_s) begin
            target_r    <= target;
            settle_r    <= SETTLE_LOAD;
            cnt_clr_n_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= CLR;
          end else begin
            cnt_clr_n_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        CLR: begin
          if (abort) begin
            cnt_en_r    <= 1'b0;
            cnt_clr_n_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else if (settle_r == 3'd0) begin
            cnt_clr_n_r <= 1'b1;
            if (remaining_s != REM_ZERO) begin
              cnt_en_r <= ~pause;
              state_r  <= RUN;
            end else begin
              cnt_en_r <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end
          end else begin
            settle_r <= settle_r - 3'd1;
          end
        end
        RUN: begin
          if (abort) begin
            cnt_en_r    <= 1'b0;
            cnt_clr_n_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else if (cnt_en_r && (remaining_s == REM_ONE)) begin
            // This edge delivers the last increment.
            cnt_en_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            cnt_en_r <= ~pause;
          end
        end
        DONE: begin
          cnt_en_r    <= 1'b0;
          cnt_clr_n_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          cnt_en_r    <= 1'b0;
          cnt_clr_n_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  count_seq_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clock   (clock),
    .clear   (clear),
    .restart (start_acc_s),
    .inc     (shadow_inc_s),
    .check   (check_win_s),
    .q       (q),
    .shadow  (shadow_s),
    .err     (err)
  );

  assign cnt_en    = cnt_en_r;
  assign cnt_clr_n = cnt_clr_n_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl (WIDTH=4, SETTLE=1) with a behavioural
// master-slave counter model driving q: it loads on the rising edge and
// presents Q on the falling edge.
module tb_count_seq_ctrl;

`ifdef COUNT_SEQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clock;
  logic       clear;
  logic       start;
  logic [3:0] target;
  logic       pause;
  logic       abort;
  logic [3:0] q;
  logic       cnt_en;
  logic       cnt_clr_n;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] master_m = 4'd0;
  logic [3:0] q_m      = 4'd0;
  logic       stuck    = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       clr;
    logic       st;
    logic       ab;
    logic       pa;
    logic [3:0] tg;
    logic       e_en;
    logic       e_clrn;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_q;
  } vec_t;

  vec_t vecs[$];

  count_seq_ctrl dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .target    (target),
    .pause     (pause),
    .abort     (abort),
    .q         (q),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counter master stage: clear or increment at the rising edge.
  always @(posedge clock) begin
    if (cnt_clr_n === 1'b0) master_m <= 4'd0;
    else if (cnt_en === 1'b1) master_m <= master_m + 4'd1;
  end

  // Counter slave stage: Q follows the master at the falling edge.
  always @(negedge clock) q_m <= master_m;

  assign q = stuck ? 4'd2 : q_m;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic clr, input logic st, input logic ab, input logic pa, input logic [3:0] tg,
                     input logic e_en, input logic e_clrn, input logic e_busy, input logic e_done,
                     input logic [3:0] e_q);
    vec_t v;
    v.clr = clr; v.st = st; v.ab = ab; v.pa = pa; v.tg = tg;
    v.e_en = e_en; v.e_clrn = e_clrn; v.e_busy = e_busy; v.e_done = e_done; v.e_q = e_q;
    vecs.push_back(v);
  endtask

  // Start a sequence at edge 0, pause over edges p_lo..p_hi, run until one cycle after done.
  task automatic run_seq(input logic [3:0] t, input int p_lo, input int p_hi,
                         output int en_cnt, output int done_at, output int done_cnt,
                         output logic err0, output logic err5);
    start = 1'b1; target = t;
    @(posedge clock); #1;
    start = 1'b0;
    err0 = err; err5 = 1'b0;
    en_cnt = 0; done_at = -1; done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      pause = (k >= p_lo) && (k <= p_hi);
      @(posedge clock); #1;
      if (cnt_en) en_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 5) err5 = err;
      if ((done_at >= 0) && (k > done_at)) break;
    end
    pause = 1'b0;
  endtask

  int   en_cnt, done_at, done_cnt;
  logic err0, err5;

  initial begin
    clear = 1'b0; start = 1'b0; target = 4'd0; pause = 1'b0; abort = 1'b0;

    //   clr st ab pa tg     en clrn busy done q
    add(0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0);   // reset
    add(0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 4'd0,  0, 1, 0, 0, 4'd0);   // idle
    add(1, 1, 0, 0, 4'd5,  0, 0, 1, 0, 4'd0);   // target=5: CLR
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd0);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd0);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd1);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd2);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd3);
    add(1, 0, 0, 0, 4'd0,  0, 1, 1, 1, 4'd4);   // done in cycle 7
    add(1, 0, 0, 0, 4'd0,  0, 1, 0, 0, 4'd5);
    add(1, 1, 0, 0, 4'd0,  0, 0, 1, 0, 4'd5);   // target=0: CLR
    add(1, 0, 0, 0, 4'd0,  0, 1, 1, 1, 4'd5);   // straight to DONE
    add(1, 0, 0, 0, 4'd0,  0, 1, 0, 0, 4'd0);
    add(1, 1, 1, 0, 4'd7,  0, 1, 0, 0, 4'd0);   // start+abort in IDLE
    add(1, 1, 0, 0, 4'd9,  0, 0, 1, 0, 4'd0);   // target=9, abort later
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd0);
    add(1, 1, 0, 0, 4'd2,  1, 1, 1, 0, 4'd0);   // start while busy ignored
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd1);
    add(1, 0, 1, 0, 4'd0,  0, 1, 0, 0, 4'd2);   // abort on 3rd enable
    add(1, 0, 0, 0, 4'd0,  0, 1, 0, 0, 4'd3);
    add(1, 0, 0, 0, 4'd0,  0, 1, 0, 0, 4'd3);   // q holds, no done
    add(1, 1, 0, 0, 4'd7,  0, 0, 1, 0, 4'd3);   // target=7, reset mid-run
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd3);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd0);
    add(0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd1);   // clear low
    add(1, 1, 0, 0, 4'd4,  0, 0, 1, 0, 4'd2);   // fresh target=4
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd0);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd0);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd1);
    add(1, 0, 0, 0, 4'd0,  1, 1, 1, 0, 4'd2);
    add(1, 0, 0, 0, 4'd0,  0, 1, 1, 1, 4'd3);
    add(1, 0, 0, 0, 4'd0,  0, 1, 0, 0, 4'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; start = vecs[i].st; abort = vecs[i].ab;
      pause = vecs[i].pa;  target = vecs[i].tg;
      @(posedge clock); #1;
      chk("cnt_en",    i, {7'd0, cnt_en},    {7'd0, vecs[i].e_en});
      chk("cnt_clr_n", i, {7'd0, cnt_clr_n}, {7'd0, vecs[i].e_clrn});
      chk("busy",      i, {7'd0, busy},      {7'd0, vecs[i].e_busy});
      chk("done",      i, {7'd0, done},      {7'd0, vecs[i].e_done});
      chk("err",       i, {7'd0, err},       8'd0);
      chk("q",         i, {4'd0, q},         {4'd0, vecs[i].e_q});
    end
    start = 1'b0; abort = 1'b0; clear = 1'b1;

    // target=15 with pause sampled at edges 5..7
    run_seq(4'd15, 5, 7, en_cnt, done_at, done_cnt, err0, err5);
    chk("p15_en_cycles",  0, 8'(en_cnt),   8'd15);
    chk("p15_done_cycle", 0, 8'(done_at + 1), 8'd20);
    chk("p15_done_count", 0, 8'(done_cnt), 8'd1);
    chk("p15_final_q",    0, {4'd0, q},    8'd15);
    chk("p15_err",        0, {7'd0, err},  8'd0);

    // q stuck at 2 during a target=6 run
    stuck = 1'b1;
    run_seq(4'd6, 100, 100, en_cnt, done_at, done_cnt, err0, err5);
    chk("stk_en_cycles",  0, 8'(en_cnt),     8'd6);
    chk("stk_done_cycle", 0, 8'(done_at + 1), 8'd8);
    chk("stk_err_by_4th", 0, {7'd0, err5},   {7'd0, CHK});
    chk("stk_err_sticky", 0, {7'd0, err},    {7'd0, CHK});
    stuck = 1'b0;

    // next accepted start clears err
    run_seq(4'd1, 100, 100, en_cnt, done_at, done_cnt, err0, err5);
    chk("rst_err_start",  0, {7'd0, err0},   8'd0);
    chk("t1_en_cycles",   0, 8'(en_cnt),     8'd1);
    chk("t1_done_cycle",  0, 8'(done_at + 1), 8'd3);
    chk("t1_final_q",     0, {4'd0, q},      8'd1);
    chk("t1_err",         0, {7'd0, err},    8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Sequencing controller for the 4-bit master-slave JK synchronous counter. Accepts a start command with a target count, clears the counter, drives its count-enable for exactly `target` increments, supports pause and abort, and signals completion. An optional shadow checker compares the counter's Q against an internally tracked expected count and flags divergence. Sits between the system control logic and the counter's `count_enable`/`clear` pins.

## Interface
- `WIDTH`, 4: counter width; `target`, `q`, and shadow widths.
- `SETTLE`, 1: cycles `cnt_clr_n` is held low before counting (1..7).

- `clock` in 1: single clock, rising edge.
- `clear` in 1: synchronous, active-low reset.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `target` in WIDTH: number of increments; latched with `start`.
- `pause` in 1: level; suspends counting while high in RUN.
- `abort` in 1: returns to IDLE from any state.
- `q` in WIDTH: counter output Q[3:0].
- `cnt_en` out 1: to counter `count_enable`; registered.
- `cnt_clr_n` out 1: to counter `clear`, active-low; registered.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky Q/shadow mismatch flag (see Configuration).

## Operation
- Reset (`clear`=0 at an edge): state IDLE. `cnt_en`=0, `cnt_clr_n`=0, `busy`=0, `done`=0, `err`=0, shadow=0, remaining=0.
- IDLE: `cnt_clr_n`=1, `cnt_en`=0. On `start`=1: latch `target` into remaining, zero the shadow, clear `err`, and go to CLR.
- CLR: `cnt_clr_n`=0 for SETTLE cycles. Then go to RUN if remaining≠0, else DONE.
- RUN: `cnt_en`=1 while `pause`=0. At each edge where `cnt_en`=1, the shadow increments mod 2^WIDTH and remaining decrements. When remaining reaches 0, `cnt_en` is 0 and the state becomes DONE. While `pause`=1, `cnt_en` is 0 on the following cycle and shadow and remaining hold.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort`=1 in any non-IDLE state: IDLE next edge, `cnt_en`=0, `cnt_clr_n`=1 (counter value retained), no `done`. `abort` has priority over `pause` and completion.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: stay IDLE.
- `target`=0: CLR→DONE. Zero enables.
- `target`=15 (WIDTH=4): 15 increments. Final Q is 15, no wrap. Shadow arithmetic still wraps mod 2^WIDTH.

## Timing
- All outputs are registered. No combinational input→output paths.
- `start` sampled at edge 0 → `cnt_clr_n` low during cycles 1..SETTLE → `cnt_en` high during cycles SETTLE+1..SETTLE+target (no pause) → `done` high in cycle SETTLE+target+1.
- Each cycle of `pause` extends the sequence by one cycle.
- Counter latches at the rising edge and Q updates at the falling edge. The `q` sampled at edge k+1 therefore reflects the increment enabled at edge k. The checker compares `q` against the shadow value held before edge k+1 updates it.
- Reset asserted mid-sequence: IDLE at that edge and all outputs return to their reset values. No `done`.

## Configuration
- `COUNT_SEQ_CHECK_EN` defined: the shadow checker is compiled in. In RUN and DONE, and during pause, any edge where `q`≠shadow sets `err`=1. `err` clears only on reset or accepted `start`.
- Not defined: checker logic is absent and `err` is tied to 0. The shadow register is still used to track remaining.

## Structure
- Shared package `count_seq_pkg`: state enum (IDLE, CLR, RUN, DONE), default WIDTH/SETTLE constants.
- One sub-module: `count_seq_shadow` (shadow counter plus optional comparator, guarded by the macro).
- FSM and remaining/settle counters live in the top module.

## Test plan
- Reset then `start`, `target`=5, SETTLE=1 → `cnt_clr_n` low 1 cycle, `cnt_en` high exactly 5 cycles, `done` pulses at cycle 7, final q=5, `err`=0.
- `target`=0 → no `cnt_en`, `done` at cycle SETTLE+1.
- `target`=15 with `pause` high for 3 cycles mid-run → 15 enable cycles, `done` at cycle 1+15+3+1=20, q=15.
- `abort` after 3 enables → IDLE next edge, `cnt_en`=0, no `done`, q holds 3. `start` asserted during RUN is ignored.
- With `COUNT_SEQ_CHECK_EN`: force q stuck at 2 during a `target`=6 run → `err`=1 by the 4th compare and remains set through `done`. It clears on the next `start`.
- `clear`=0 mid-RUN → all outputs at reset values the next cycle. A fresh `start` with `target`=4 then completes normally.
